seq_signed_comparator: RTL and testbench

// Multi-cycle magnitude comparator for signed or unsigned operands, selected per

---
 rtl/seq_cmp_if.sv | 32 +++
 rtl/seq_signed_comparator.sv | 137 +++++++++++++
 tb/tb_seq_signed_comparator.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_cmp_if.sv
// Operand/result handshake bundle for the sequential magnitude comparator.
// Valid/ready rule on both channels: a beat transfers on a rising edge where
// valid and ready are both 1. The producer holds its payload stable while
// valid=1 and ready=0. The consumer reads results only while out_valid=1.
interface seq_cmp_if #(
  parameter int SIZE = 8
);
  logic            in_valid;
  logic            in_ready;
  logic [SIZE-1:0] a;
  logic [SIZE-1:0] b;
  logic            signed_mode;
  logic            out_valid;
  logic            out_ready;
  logic            is_a_greater;
  logic            equal;
  logic            is_a_less;
  logic [SIZE-1:0] max_val;
  logic [SIZE-1:0] min_val;

  // Operand source and result sink (ALU side)
  modport master (
    output in_valid, a, b, signed_mode, out_ready,
    input  in_ready, out_valid, is_a_greater, equal, is_a_less, max_val, min_val
  );

  // Comparator side
  modport slave (
    input  in_valid, a, b, signed_mode, out_ready,
    output in_ready, out_valid, is_a_greater, equal, is_a_less, max_val, min_val
  );
endinterface

// File: rtl/seq_signed_comparator.sv
// Multi-cycle signed/unsigned magnitude comparator. It scans CHUNK bits per
// clock from MSB to LSB and stops at the first chunk that differs.
// Signed mode flips the MSB of both operands so that one unsigned scan orders
// two's-complement values correctly. max_val/min_val carry the original operands.
// state_dbg exposes the FSM state: 0=IDLE 1=COMPARE 2=SETTLE 3=DONE.
module seq_signed_comparator #(
  parameter int SIZE  = 8,
  parameter int CHUNK = 2
) (
  input  logic       clk,
  input  logic       rst,
  seq_cmp_if.slave   bus,
  output logic [1:0] state_dbg
);

  localparam int NCHUNK = SIZE / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [SIZE-1:0] MSB_MASK = {1'b1, {(SIZE-1){1'b0}}};

  // SETTLE is the one cycle in which the decided result sits in the output
  // registers before out_valid rises. This gives k+1 edges from accept to
  // out_valid.
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPARE = 2'd1,
    S_SETTLE  = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [SIZE-1:0]    a_q;
  logic [SIZE-1:0]    b_q;
  logic               signed_q;
  logic [IDX_W-1:0]   idx;
  logic [SIZE-1:0]    a_cmp;
  logic [SIZE-1:0]    b_cmp;
  logic [CHUNK-1:0]   chunk_a;
  logic [CHUNK-1:0]   chunk_b;
  logic               chunk_ne;
  logic               chunk_gt;
  logic               last_chunk;
  logic               out_valid_q;
  logic               gt_q;
  logic               eq_q;
  logic               lt_q;
  logic [SIZE-1:0]    max_q;
  logic [SIZE-1:0]    min_q;

  // Select the current chunk of the order-preserving transformed operands
  always_comb begin
    a_cmp      = signed_q ? (a_q ^ MSB_MASK) : a_q;
    b_cmp      = signed_q ? (b_q ^ MSB_MASK) : b_q;
    chunk_a    = a_cmp[int'(idx)*CHUNK +: CHUNK];
    chunk_b    = b_cmp[int'(idx)*CHUNK +: CHUNK];
    chunk_ne   = (chunk_a != chunk_b);
    chunk_gt   = (chunk_a > chunk_b);
    last_chunk = (idx == '0);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    if (bus.in_valid)           state_next = S_COMPARE;
      S_COMPARE: if (chunk_ne || last_chunk) state_next = S_SETTLE;
      S_SETTLE:                              state_next = S_DONE;
      S_DONE:    if (bus.out_ready)          state_next = S_IDLE;
      default:                               state_next = S_IDLE;
    endcase
  end

  // Output decode: ready is a combinational state decode; everything else is registered
  always_comb begin
    bus.in_ready     = (state == S_IDLE);
    bus.out_valid    = out_valid_q;
    bus.is_a_greater = gt_q;
    bus.equal        = eq_q;
    bus.is_a_less    = lt_q;
    bus.max_val      = max_q;
    bus.min_val      = min_q;
    state_dbg        = state;
  end

  // Operand capture, chunk walk and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q         <= '0;
      b_q         <= '0;
      signed_q    <= 1'b0;
      idx         <= '0;
      out_valid_q <= 1'b0;
      gt_q        <= 1'b0;
      eq_q        <= 1'b0;
      lt_q        <= 1'b0;
      max_q       <= '0;
      min_q       <= '0;
    end else begin
      out_valid_q <= (state_next == S_DONE);
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            a_q      <= bus.a;
            b_q      <= bus.b;
            signed_q <= bus.signed_mode;
            idx      <= IDX_W'(NCHUNK - 1);
          end
        end
        S_COMPARE: begin
          if (chunk_ne) begin
            gt_q  <= chunk_gt;
            eq_q  <= 1'b0;
            lt_q  <= ~chunk_gt;
            max_q <= chunk_gt ? a_q : b_q;
            min_q <= chunk_gt ? b_q : a_q;
          end else if (last_chunk) begin
            gt_q  <= 1'b0;
            eq_q  <= 1'b1;
            lt_q  <= 1'b0;
            max_q <= a_q;
            min_q <= a_q;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_signed_comparator.sv
// Directed bench for seq_signed_comparator (SIZE=8, CHUNK=2).
// Inputs are driven on the falling edge and outputs are sampled on the falling edge.
module tb_seq_signed_comparator;

  logic       clk;
  logic       rst;
  logic [1:0] state_dbg;
  int         n_cmp;
  int         n_fail;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       mode;
    logic [2:0] flags;  // {gt, eq, lt}
    logic [7:0] mx;
    logic [7:0] mn;
    int         lat;
  } vec_t;

  seq_cmp_if #(.SIZE(8)) bus ();

  seq_signed_comparator #(.SIZE(8), .CHUNK(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drives one operand pair and waits for out_valid, counting edges after the
  // accept edge. lat is left at 0 if out_valid never arrives. The task returns
  // on a falling edge. If release_out is set, the result is also consumed and
  // the task returns on the falling edge after that.
  task automatic run_txn(input logic [7:0] ta, input logic [7:0] tb_v, input logic mode,
                         input bit release_out, output int lat, output logic [2:0] flags,
                         output logic [7:0] mx, output logic [7:0] mn);
    @(negedge clk);
    bus.in_valid    = 1'b1;
    bus.a           = ta;
    bus.b           = tb_v;
    bus.signed_mode = mode;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.out_valid === 1'b1) begin
        lat = n;
        break;
      end
    end
    flags = {bus.is_a_greater, bus.equal, bus.is_a_less};
    mx    = bus.max_val;
    mn    = bus.min_val;
    if (release_out) begin
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.signed_mode = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
    end
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
    end
    n_cmp++;
    if ({bus.is_a_greater, bus.equal, bus.is_a_less, bus.max_val, bus.min_val} !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got flags=%b max=%h min=%h want all zero",
               {bus.is_a_greater, bus.equal, bus.is_a_less}, bus.max_val, bus.min_val);
    end
    n_cmp++;
    if (state_dbg !== 2'd0) begin
      n_fail++; $display("FAIL reset_state: got %0d want 0", state_dbg);
    end
    rst = 1'b0;
  endtask

  task automatic test_unsigned();
    vec_t v[6];
    int lat;
    logic [2:0] fl;
    logic [7:0] mx, mn;
    v[0] = '{8'h80, 8'h7F, 1'b0, 3'b100, 8'h80, 8'h7F, 2};
    v[1] = '{8'h5A, 8'h5A, 1'b0, 3'b010, 8'h5A, 8'h5A, 5};
    v[2] = '{8'h13, 8'h12, 1'b0, 3'b100, 8'h13, 8'h12, 5};
    v[3] = '{8'h00, 8'hFF, 1'b0, 3'b001, 8'hFF, 8'h00, 2};
    v[4] = '{8'h34, 8'h38, 1'b0, 3'b001, 8'h38, 8'h34, 4};
    v[5] = '{8'h40, 8'h50, 1'b0, 3'b001, 8'h50, 8'h40, 3};
    for (int i = 0; i < 6; i++) begin
      run_txn(v[i].a, v[i].b, v[i].mode, 1'b1, lat, fl, mx, mn);
      n_cmp++;
      if (lat !== v[i].lat) begin
        n_fail++; $display("FAIL unsigned[%0d]_latency: got %0d want %0d", i, lat, v[i].lat);
      end
      n_cmp++;
      if (fl !== v[i].flags) begin
        n_fail++; $display("FAIL unsigned[%0d]_flags: got %b want %b", i, fl, v[i].flags);
      end
      n_cmp++;
      if ({mx, mn} !== {v[i].mx, v[i].mn}) begin
        n_fail++;
        $display("FAIL unsigned[%0d]_maxmin: got %h/%h want %h/%h", i, mx, mn, v[i].mx, v[i].mn);
      end
      n_cmp++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL unsigned[%0d]_release: got in_ready=%b out_valid=%b want 1/0",
                 i, bus.in_ready, bus.out_valid);
      end
    end
  endtask

  task automatic test_signed();
    vec_t v[5];
    int lat;
    logic [2:0] fl;
    logic [7:0] mx, mn;
    v[0] = '{8'h80, 8'h7F, 1'b1, 3'b001, 8'h7F, 8'h80, 2};
    v[1] = '{8'h5A, 8'h5A, 1'b1, 3'b010, 8'h5A, 8'h5A, 5};
    v[2] = '{8'hFF, 8'hFE, 1'b1, 3'b100, 8'hFF, 8'hFE, 5};
    v[3] = '{8'h00, 8'hFF, 1'b1, 3'b100, 8'h00, 8'hFF, 2};
    v[4] = '{8'hF0, 8'h10, 1'b1, 3'b001, 8'h10, 8'hF0, 2};
    for (int i = 0; i < 5; i++) begin
      run_txn(v[i].a, v[i].b, v[i].mode, 1'b1, lat, fl, mx, mn);
      n_cmp++;
      if (lat !== v[i].lat) begin
        n_fail++; $display("FAIL signed[%0d]_latency: got %0d want %0d", i, lat, v[i].lat);
      end
      n_cmp++;
      if (fl !== v[i].flags) begin
        n_fail++; $display("FAIL signed[%0d]_flags: got %b want %b", i, fl, v[i].flags);
      end
      n_cmp++;
      if ({mx, mn} !== {v[i].mx, v[i].mn}) begin
        n_fail++;
        $display("FAIL signed[%0d]_maxmin: got %h/%h want %h/%h", i, mx, mn, v[i].mx, v[i].mn);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic [2:0] fl;
    logic [7:0] mx, mn;
    bit seen;
    run_txn(8'h21, 8'h43, 1'b0, 1'b0, lat, fl, mx, mn);
    n_cmp++;
    if (lat !== 2 || fl !== 3'b001) begin
      n_fail++; $display("FAIL bp_result: got lat=%0d flags=%b want 2/001", lat, fl);
    end
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.a = 8'hF0 + 8'(i);
      bus.b = 8'h00;
      @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]_handshake: got out_valid=%b in_ready=%b want 1/0",
                 i, bus.out_valid, bus.in_ready);
      end
      n_cmp++;
      if ({bus.is_a_greater, bus.equal, bus.is_a_less, bus.max_val, bus.min_val} !==
          {3'b001, 8'h43, 8'h21}) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]_outputs: got flags=%b max=%h min=%h want 001/43/21", i,
                 {bus.is_a_greater, bus.equal, bus.is_a_less}, bus.max_val, bus.min_val);
      end
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    n_cmp++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release: got in_ready=%b out_valid=%b want 1/0", bus.in_ready, bus.out_valid);
    end
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_fail++; $display("FAIL bp_ignored_pulse: got out_valid=1 want no result");
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [2:0] fl;
    logic [7:0] mx, mn;
    bit seen;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a = 8'h5A;
    bus.b = 8'h5A;
    bus.signed_mode = 1'b0;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (state_dbg !== 2'd1) begin
      n_fail++; $display("FAIL rstmid_in_compare: got state %0d want 1", state_dbg);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_handshake: got in_ready=%b out_valid=%b want 1/0", bus.in_ready, bus.out_valid);
    end
    n_cmp++;
    if ({bus.is_a_greater, bus.equal, bus.is_a_less, bus.max_val, bus.min_val} !== 19'd0) begin
      n_fail++;
      $display("FAIL rstmid_outputs: got flags=%b max=%h min=%h want all zero",
               {bus.is_a_greater, bus.equal, bus.is_a_less}, bus.max_val, bus.min_val);
    end
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_no_result: got out_valid=1 want none");
    end
    run_txn(8'h40, 8'h50, 1'b0, 1'b1, lat, fl, mx, mn);
    n_cmp++;
    if (lat !== 3 || fl !== 3'b001 || {mx, mn} !== {8'h50, 8'h40}) begin
      n_fail++;
      $display("FAIL rstmid_recover: got lat=%0d flags=%b max=%h min=%h want 3/001/50/40", lat, fl, mx, mn);
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_unsigned();
    test_signed();
    test_backpressure();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
